// File: rtl/program_mem_controller.sv
// rtl/program_mem_controller.sv - round-robin arbiter sharing one program-memory read port among fetchers
module program_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] grant;
    logic [IDX_BITS-1:0] pick;
    logic [IDX_BITS-1:0] pick_lo;
    logic [IDX_BITS-1:0] pick_hi;
    logic                found;
    logic                found_hi;
    logic [ADDR_BITS-1:0] pick_address;

    // Channels at or above rr_ptr take precedence; otherwise wrap to the lowest valid one.
    always_comb begin
        pick_lo  = '0;
        pick_hi  = '0;
        found    = 1'b0;
        found_hi = 1'b0;
        for (int c = NUM_CONSUMERS - 1; c >= 0; c--) begin
            if (consumer_read_valid[c]) begin
                found   = 1'b1;
                pick_lo = IDX_BITS'(c);
                if (c >= int'(rr_ptr)) begin
                    found_hi = 1'b1;
                    pick_hi  = IDX_BITS'(c);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        pick_address = '0;
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (IDX_BITS'(c) == pick) begin
                pick_address = consumer_read_address[c];
            end
        end
    end

    // The RELEASE cycle gives the fetcher one edge to advance its address before re-arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant               <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                consumer_read_data[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= pick_address;
                        grant            <= pick;
                        state            <= WAITING;
                    end
                end
                WAITING: begin
                    if (mem_read_ready) begin
                        for (int c = 0; c < NUM_CONSUMERS; c++) begin
                            if (IDX_BITS'(c) == grant) begin
                                consumer_read_data[c]  <= mem_read_data;
                                consumer_read_ready[c] <= 1'b1;
                            end
                        end
                        mem_read_valid <= 1'b0;
                        state          <= RELEASE;
                    end
                end
                RELEASE: begin
                    consumer_read_ready <= '0;
                    rr_ptr              <= (int'(grant) >= NUM_CONSUMERS - 1) ? '0 : grant + 1'b1;
                    state               <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_mem_controller.sv
// tb/tb_program_mem_controller.sv - randomized self-checking bench for program_mem_controller
module tb_program_mem_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  valid;
    logic [7:0]  caddr [4];
    logic [3:0]  rdy;
    logic [15:0] cdata [4];
    logic        mrv;
    logic [7:0]  mra;
    logic        mrr;
    logic [15:0] mrd;

    logic [0:0]  valid1;
    logic [7:0]  caddr1 [1];
    logic [0:0]  rdy1;
    logic [15:0] cdata1 [1];
    logic        mrv1;
    logic [7:0]  mra1;
    logic        mrr1;
    logic [15:0] mrd1;

    program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(valid), .consumer_read_address(caddr),
        .consumer_read_ready(rdy), .consumer_read_data(cdata),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd)
    );

    program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(valid1), .consumer_read_address(caddr1),
        .consumer_read_ready(rdy1), .consumer_read_data(cdata1),
        .mem_read_valid(mrv1), .mem_read_address(mra1),
        .mem_read_ready(mrr1), .mem_read_data(mrd1)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] mem [256];

    bit resp_en  = 1'b1;
    bit rand_lat = 1'b0;
    bit noise    = 1'b0;
    int mem_lat  = 0;
    int cur_lat  = 0;
    int cnt      = 0;

    // Program memory model: answers cur_lat cycles after the request, optional spurious ready when idle.
    initial begin
        mrr = 1'b0;
        mrd = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                cnt = 0;
            end else if (!reset) begin
                mrr = 1'b0;
                cnt = 0;
            end else if (mrv && !mrr) begin
                if (cnt >= cur_lat) begin
                    mrr = 1'b1;
                    mrd = mem[mra];
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt     = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                if (noise && !mrv) begin
                    mrr = 1'($urandom_range(0, 1));
                    mrd = 16'($urandom);
                end else begin
                    mrr = 1'b0;
                end
            end
        end
    end

    logic [7:0]       g_addr   [$];
    logic [3:0]       g_valid  [$];
    logic [3:0][7:0]  g_chaddr [$];
    logic [3:0]       r_vec    [$];
    logic [15:0]      r_data   [$];
    int multi_hot  = 0;
    int long_pulse = 0;
    int addr_moves = 0;
    logic       prev_mrv = 1'b0;
    logic [7:0] prev_mra = '0;
    logic [3:0] prev_rdy = '0;

    // Passive log of grants and responses, sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev_mrv = 1'b0;
                prev_rdy = '0;
            end else begin
                if (mrv && !prev_mrv) begin
                    logic [3:0][7:0] snap;
                    for (int c = 0; c < 4; c++) snap[c] = caddr[c];
                    g_addr.push_back(mra);
                    g_valid.push_back(valid);
                    g_chaddr.push_back(snap);
                end
                if (mrv && prev_mrv && mra !== prev_mra) addr_moves++;
                if (rdy != 4'b0) begin
                    logic [15:0] d;
                    d = '0;
                    for (int c = 3; c >= 0; c--) if (rdy[c]) d = cdata[c];
                    if ($countones(rdy) != 1) multi_hot++;
                    if (prev_rdy != 4'b0) long_pulse++;
                    r_vec.push_back(rdy);
                    r_data.push_back(d);
                end
                prev_mrv = mrv;
                prev_mra = mra;
                prev_rdy = rdy;
            end
        end
    end

    task automatic clear_logs();
        g_addr.delete();
        g_valid.delete();
        g_chaddr.delete();
        r_vec.delete();
        r_data.delete();
        multi_hot  = 0;
        long_pulse = 0;
        addr_moves = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        valid  = '0;
        valid1 = '0;
        mrr1   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic wait_resp(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (r_vec.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        mem[8'h7E] = 16'hC3C3;
        rand_lat = 1'b0;
        mem_lat  = 0;
        @(negedge clk);
        caddr[3] = 8'h7E;
        valid    = 4'b1000;
        wait_resp(1, 20, ok);
        valid = '0;
        tests++; if (!ok) begin fails++; $display("FAIL reset_setup_resp: got none expected a response"); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (mrv !== 1'b0) begin fails++; $display("FAIL reset_mrv: got %b expected 0", mrv); end
        tests++; if (mra !== 8'h00) begin fails++; $display("FAIL reset_mra: got %h expected 00", mra); end
        tests++; if (rdy !== 4'h0) begin fails++; $display("FAIL reset_rdy: got %b expected 0000", rdy); end
        for (int c = 0; c < 4; c++) begin
            tests++; if (cdata[c] !== 16'h0) begin fails++; $display("FAIL reset_data%0d: got %h expected 0000", c, cdata[c]); end
        end
        tests++; if (mrv1 !== 1'b0 || rdy1 !== 1'b0 || cdata1[0] !== 16'h0) begin
            fails++; $display("FAIL reset_n1: got %b/%b/%h expected 0/0/0000", mrv1, rdy1, cdata1[0]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        rand_lat = 1'b0;
        noise    = 1'b0;
        mem_lat  = 0;
        mem[8'h12] = 16'hABCD;
        @(negedge clk);
        caddr[0] = 8'h12;
        valid    = 4'b0001;
        @(posedge clk); #1;
        tests++; if (mrv !== 1'b1 || mra !== 8'h12) begin fails++; $display("FAIL single_req: got %b/%h expected 1/12", mrv, mra); end
        tests++; if (rdy !== 4'h0) begin fails++; $display("FAIL single_early_rdy: got %b expected 0000", rdy); end
        @(posedge clk); #1;
        tests++; if (rdy !== 4'b0001) begin fails++; $display("FAIL single_rdy: got %b expected 0001", rdy); end
        tests++; if (cdata[0] !== 16'hABCD) begin fails++; $display("FAIL single_data: got %h expected abcd", cdata[0]); end
        tests++; if (mrv !== 1'b0) begin fails++; $display("FAIL single_mrv_drop: got %b expected 0", mrv); end
        @(posedge clk); #1;
        tests++; if (rdy !== 4'h0 || mrv !== 1'b0) begin fails++; $display("FAIL single_release: got %b/%b expected 0000/0", rdy, mrv); end
        @(posedge clk); #1;
        tests++; if (mrv !== 1'b1) begin fails++; $display("FAIL single_regrant_3cyc: got %b expected 1", mrv); end
        @(negedge clk);
        valid = '0;
        wait_resp(2, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_second_resp: got %0d expected 2", r_vec.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        rand_lat = 1'b1;
        noise    = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) caddr[c] = 8'(c * 16);
        valid = 4'hF;
        wait_resp(5, 60, ok);
        valid = '0;
        tests++; if (!ok) begin fails++; $display("FAIL rr_timeout: got %0d expected 5 responses", r_vec.size()); end
        wait_resp(g_addr.size(), 30, ok);
        tests++; if (g_addr.size() != 5) begin fails++; $display("FAIL rr_grants: got %0d expected 5", g_addr.size()); end
        for (int i = 0; i < g_addr.size() && i < 5; i++) begin
            tests++; if (g_addr[i] !== 8'((i % 4) * 16)) begin
                fails++; $display("FAIL rr_order%0d: got %h expected %h", i, g_addr[i], 8'((i % 4) * 16));
            end
        end
        for (int c = 0; c < 4; c++) begin
            tests++; if (cdata[c] !== mem[8'(c * 16)]) begin
                fails++; $display("FAIL rr_hold%0d: got %h expected %h", c, cdata[c], mem[8'(c * 16)]);
            end
        end
    endtask

    task automatic test_addr_step();
        bit ok;
        do_reset();
        rand_lat = 1'b1;
        @(negedge clk);
        caddr[1] = 8'h05;
        valid    = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_resp(k + 1, 40, ok);
            tests++; if (!ok) begin fails++; $display("FAIL step_timeout%0d: got none expected response", k); end
            caddr[1] = caddr[1] + 8'h01;
        end
        valid = '0;
        wait_resp(g_addr.size(), 30, ok);
        tests++; if (g_addr.size() != 3) begin fails++; $display("FAIL step_grants: got %0d expected 3", g_addr.size()); end
        for (int i = 0; i < g_addr.size() && i < 3; i++) begin
            tests++; if (g_addr[i] !== 8'(5 + i)) begin fails++; $display("FAIL step_addr%0d: got %h expected %h", i, g_addr[i], 8'(5 + i)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rand_lat   = 1'b0;
        mem_lat    = 5;
        mem[8'h44] = 16'h5A5A;
        @(negedge clk);
        caddr[2] = 8'h44;
        valid    = 4'b0100;
        @(posedge clk); #1;
        tests++; if (mrv !== 1'b1 || mra !== 8'h44) begin fails++; $display("FAIL stall_grant: got %b/%h expected 1/44", mrv, mra); end
        @(negedge clk);
        caddr[2] = 8'h99;
        valid    = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if ({mrv, mra, rdy} !== {1'b1, 8'h44, 4'h0}) begin
                fails++; $display("FAIL stall_hold%0d: got %b/%h/%b expected 1/44/0000", i, mrv, mra, rdy);
            end
        end
        @(posedge clk); #1;
        tests++; if (rdy !== 4'b0100 || cdata[2] !== 16'h5A5A) begin
            fails++; $display("FAIL stall_resp: got %b/%h expected 0100/5a5a", rdy, cdata[2]);
        end
        mem_lat = 0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        rand_lat = 1'b0;
        mem_lat  = 0;
        @(negedge clk);
        caddr[0] = 8'h21;
        caddr[2] = 8'h23;
        valid    = 4'b0001;
        wait_resp(1, 20, ok);
        valid = '0;
        @(negedge clk);
        @(negedge clk);
        mem_lat = 10;
        @(negedge clk);
        valid = 4'b0101;
        @(posedge clk); #1;
        tests++; if (mrv !== 1'b1 || mra !== 8'h23) begin fails++; $display("FAIL midrst_rr_grant: got %b/%h expected 1/23", mrv, mra); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (mrv !== 1'b0 || mra !== 8'h00 || rdy !== 4'h0) begin
            fails++; $display("FAIL midrst_async: got %b/%h/%b expected 0/00/0000", mrv, mra, rdy);
        end
        @(negedge clk);
        reset   = 1'b1;
        resp_en = 1'b0;
        mrr     = 1'b1;
        mrd     = 16'hDEAD;
        mem_lat = 0;
        @(posedge clk); #1;
        tests++; if (mrv !== 1'b1 || mra !== 8'h21) begin fails++; $display("FAIL midrst_first_arb: got %b/%h expected 1/21", mrv, mra); end
        tests++; if (rdy !== 4'h0 || r_vec.size() != 1) begin
            fails++; $display("FAIL midrst_no_pulse: got %b/%0d expected 0000/1", rdy, r_vec.size());
        end
        @(negedge clk);
        valid   = '0;
        mrr     = 1'b0;
        resp_en = 1'b1;
        wait_resp(2, 40, ok);
        tests++; if (!ok || r_vec[r_vec.size()-1] !== 4'b0001 || r_data[r_data.size()-1] !== mem[8'h21]) begin
            fails++; $display("FAIL midrst_resume: got %b/%h expected 0001/%h", r_vec[r_vec.size()-1], r_data[r_data.size()-1], mem[8'h21]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int rr;
        do_reset();
        rand_lat = 1'b1;
        noise    = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) valid = 4'($urandom);
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 7) == 0) caddr[c] = 8'($urandom);
        end
        valid = '0;
        wait_resp(g_addr.size(), 60, ok);
        noise    = 1'b0;
        rand_lat = 1'b0;
        tests++; if (!ok || r_vec.size() != g_addr.size()) begin
            fails++; $display("FAIL rand_count: got %0d responses expected %0d", r_vec.size(), g_addr.size());
        end
        tests++; if (g_addr.size() < 20) begin fails++; $display("FAIL rand_activity: got %0d grants expected >=20", g_addr.size()); end
        rr = 0;
        for (int i = 0; i < g_addr.size(); i++) begin
            int ch;
            logic [7:0] ea;
            ch = -1;
            for (int k = 0; k < 4; k++) if (ch < 0 && g_valid[i][(rr + k) % 4]) ch = (rr + k) % 4;
            tests++;
            if (ch < 0) begin
                fails++; $display("FAIL rand_grant%0d: got grant expected none (valid %b)", i, g_valid[i]);
            end else begin
                ea = g_chaddr[i][ch];
                if (g_addr[i] !== ea) begin fails++; $display("FAIL rand_addr%0d: got %h expected %h", i, g_addr[i], ea); end
                if (i < r_vec.size()) begin
                    tests++; if (r_vec[i] !== 4'(1 << ch) || r_data[i] !== mem[ea]) begin
                        fails++; $display("FAIL rand_resp%0d: got %b/%h expected %b/%h", i, r_vec[i], r_data[i], 4'(1 << ch), mem[ea]);
                    end
                end
                rr = (ch + 1) % 4;
            end
        end
        tests++; if (multi_hot != 0 || long_pulse != 0 || addr_moves != 0) begin
            fails++; $display("FAIL rand_protocol: got %0d/%0d/%0d expected 0/0/0", multi_hot, long_pulse, addr_moves);
        end
    endtask

    task automatic test_single_consumer();
        int  last;
        int  npulse;
        bit  step;
        do_reset();
        caddr1[0] = 8'h40;
        valid1    = 1'b1;
        last   = -1;
        npulse = 0;
        step   = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (step) caddr1[0] = caddr1[0] + 8'h01;
            step = 1'b0;
            if (cyc == 20) valid1 = 1'b0;
            mrr1 = mrv1;
            mrd1 = mem[mra1];
            @(posedge clk); #1;
            if (rdy1 == 1'b1) begin
                tests++; if (cdata1[0] !== mem[8'(8'h40 + npulse)]) begin
                    fails++; $display("FAIL n1_data%0d: got %h expected %h", npulse, cdata1[0], mem[8'(8'h40 + npulse)]);
                end
                if (last >= 0) begin
                    tests++; if (cyc - last != 3) begin fails++; $display("FAIL n1_period%0d: got %0d expected 3", npulse, cyc - last); end
                end
                last = cyc;
                npulse++;
                step = 1'b1;
            end
        end
        mrr1 = 1'b0;
        tests++; if (npulse != 7) begin fails++; $display("FAIL n1_pulses: got %0d expected 7", npulse); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        valid     = '0;
        valid1    = '0;
        caddr1[0] = '0;
        mrr1      = 1'b0;
        mrd1      = '0;
        for (int c = 0; c < 4; c++) caddr[c] = '0;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        test_reset();
        test_single();
        test_round_robin();
        test_addr_step();
        test_stall();
        test_reset_mid_wait();
        test_random();
        test_single_consumer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
